// File: rtl/keypad_bcd_entry_if.sv
// keypad_bcd_entry_if: keypad inputs and BCD entry buffer outputs
interface keypad_bcd_entry_if #(
   parameter int NUM_DIGITS = 4
);
   localparam int CW = $clog2(NUM_DIGITS + 1);
   logic [9:0]              dec;
   logic                    en;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [CW-1:0]           count;
   logic [3:0]              last_bcd;
   logic                    strobe;
   logic                    busy;
   logic                    full;
   logic                    error;
   logic                    overflow;
   modport master (
      output dec, en, clear,
      input  digits, count, last_bcd, strobe, busy, full, error, overflow
   );
   modport slave (
      input  dec, en, clear,
      output digits, count, last_bcd, strobe, busy, full, error, overflow
   );
endinterface

// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry: debounced one-hot keypad to multi-digit BCD entry buffer
module keypad_bcd_entry #(
   parameter int NUM_DIGITS = 4,
   parameter int DEBOUNCE   = 3,
   parameter int OVERWRITE  = 1
) (
   input logic               clk,
   input logic               rst_n,
   keypad_bcd_entry_if.slave bus
);
   localparam int CW  = $clog2(NUM_DIGITS + 1);
   localparam int DW  = $clog2(DEBOUNCE + 1);
   localparam int DBW = 4 * NUM_DIGITS;

   typedef enum logic [1:0] {ST_IDLE, ST_DEB, ST_WAIT} state_t;

   state_t         r_state;
   logic [DW-1:0]  r_cnt;
   logic [3:0]     r_code;
   logic [DBW-1:0] r_digits;
   logic [CW-1:0]  r_count;
   logic [3:0]     r_last_bcd;
   logic           r_strobe;
   logic           r_error;
   logic           r_overflow;

   logic [3:0]     w_ones;
   logic [3:0]     w_code;
   logic           w_none;
   logic           w_onehot;
   logic           w_multi;
   logic           w_full;
   logic           w_take;
   logic [DBW-1:0] w_shift;
   logic [CW-1:0]  w_count_inc;
   state_t         w_next;
   logic [DW-1:0]  w_cnt_next;
   logic           w_accept;
   logic           w_err;

   // classify the keypad: number of lines asserted and index of the pressed key
   always_comb begin
      w_ones = 4'd0;
      w_code = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (bus.dec[i]) begin
            w_ones = w_ones + 4'd1;
            w_code = 4'(i);
         end
      end
   end

   assign w_none      = w_ones == 4'd0;
   assign w_onehot    = w_ones == 4'd1;
   assign w_multi     = w_ones > 4'd1;
   assign w_full      = r_count == CW'(NUM_DIGITS);
   assign w_take      = w_accept && (!w_full || OVERWRITE != 0);
   assign w_shift     = DBW'({r_digits, w_code});
   assign w_count_inc = w_full ? r_count : r_count + CW'(1);

   // press tracking: debounce a stable one-hot key, flag multi-hot, wait for release
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      w_err      = 1'b0;
      if (r_state == ST_IDLE) begin
         if (bus.en && w_multi) begin
            w_err  = 1'b1;
            w_next = ST_WAIT;
         end else if (bus.en && w_onehot) begin
            if (DEBOUNCE == 1) begin
               w_accept = 1'b1;
               w_next   = ST_WAIT;
            end else begin
               w_next     = ST_DEB;
               w_cnt_next = DW'(1);
            end
         end
      end else if (r_state == ST_DEB) begin
         if (!bus.en) begin
            w_next = ST_IDLE;
         end else if (w_multi) begin
            w_err  = 1'b1;
            w_next = ST_WAIT;
         end else if (!w_onehot || w_code != r_code) begin
            w_next = ST_IDLE;
         end else if (r_cnt + DW'(1) == DW'(DEBOUNCE)) begin
            w_accept = 1'b1;
            w_next   = ST_WAIT;
         end else begin
            w_cnt_next = r_cnt + DW'(1);
         end
      end else if (w_none) begin
         w_next = ST_IDLE;
      end
   end

   // state, buffer and flag registers; clear parks the FSM until the keypad is released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_code     <= '0;
         r_digits   <= '0;
         r_count    <= '0;
         r_last_bcd <= '0;
         r_strobe   <= 1'b0;
         r_error    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (bus.clear) begin
         r_state    <= ST_WAIT;
         r_cnt      <= '0;
         r_digits   <= '0;
         r_count    <= '0;
         r_last_bcd <= '0;
         r_strobe   <= 1'b0;
         r_error    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_cnt      <= w_cnt_next;
         r_code     <= (r_state == ST_IDLE) ? w_code : r_code;
         r_error    <= r_error | w_err;
         r_strobe   <= w_take;
         r_overflow <= w_accept && !w_take;
         r_last_bcd <= w_accept ? w_code : r_last_bcd;
         r_digits   <= w_take ? w_shift : r_digits;
         r_count    <= w_take ? w_count_inc : r_count;
      end
   end

   assign bus.digits   = r_digits;
   assign bus.count    = r_count;
   assign bus.last_bcd = r_last_bcd;
   assign bus.strobe   = r_strobe;
   assign bus.error    = r_error;
   assign bus.overflow = r_overflow;
   assign bus.full     = w_full;
   assign bus.busy     = r_state != ST_IDLE;
endmodule

// File: doc/keypad_bcd_entry.md
# keypad_bcd_entry

Registered, debounced successor to the combinational decimal-to-BCD encoder. It takes the one-hot 10-key decimal keypad of the microwave front panel and accepts one key per press, after a configurable debounce interval. Accepted digits are shifted into a multi-digit BCD entry buffer. The buffer feeds the cook-time loader and the display driver.

## Interface
- NUM_DIGITS, 4: BCD digits held in the buffer (≥1).
- DEBOUNCE, 3: consecutive cycles a key must be stable before acceptance (≥1).
- OVERWRITE, 1: 1 = when the buffer is full, a new key shifts in and drops the most-significant digit; 0 = a new key is rejected and `overflow` pulses.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec  in  10  keypad lines; bit i = key i pressed.
- en  in  1  entry enable; 0 = keypad ignored.
- clear  in  1  synchronous clear of the buffer and flags.
- digits  out  4*NUM_DIGITS  BCD buffer; digit 0 (bits 3:0) is the most recent key.
- count  out  $clog2(NUM_DIGITS+1)  number of digits entered, saturating at NUM_DIGITS.
- last_bcd  out  4  BCD code of the last accepted key.
- strobe  out  1  one-cycle pulse per accepted key.
- busy  out  1  state ≠ IDLE.
- full  out  1  count == NUM_DIGITS.
- error  out  1  sticky; set on a multi-hot press.
- overflow  out  1  one-cycle pulse on a key rejected because the buffer is full (OVERWRITE=0 only).

## Operation
- All outputs are registered except `full` and `busy`, which decode from registers.
- Reset values: digits=0, count=0, last_bcd=0, strobe=0, error=0, overflow=0, state=IDLE.
- Key classes:
  - one-hot: exactly one bit of `dec` set; code = index of that bit (0–9).
  - multi-hot: two or more bits set.
  - none: `dec` == 0.
- State IDLE:
  - en=0 or none: stay.
  - en=1, multi-hot: set error, go to WAIT_REL.
  - en=1, one-hot: latch code. If DEBOUNCE==1, accept and go to WAIT_REL. Otherwise go to DEBOUNCE with cnt=1.
- State DEBOUNCE:
  - en=0 or `dec` ≠ latched one-hot value: go to IDLE, no accept.
  - multi-hot: set error, go to WAIT_REL.
  - same value: cnt+1. When cnt+1 == DEBOUNCE, accept and go to WAIT_REL.
- State WAIT_REL: stay until `dec` == 0, then go to IDLE. A new key is never accepted without a release first.
- Accept:
  - strobe=1 and last_bcd=code.
  - If not full: digits shift left by 4 with code entering digit 0; count+1.
  - If full and OVERWRITE=1: same shift, oldest digit lost, count unchanged.
  - If full and OVERWRITE=0: digits unchanged, overflow=1, strobe=0.
- clear has the highest priority below reset:
  - digits=0, count=0, error=0, last_bcd=0, state=WAIT_REL.
  - Any accept in that cycle is suppressed.
- Width rules: the debounce counter is $clog2(DEBOUNCE+1) bits and never wraps; count saturates.

## Timing
- Acceptance latency: a key stable from before edge k is accepted at edge k+DEBOUNCE−1. `digits`, `count`, `last_bcd` and `strobe` are visible after that edge.
- strobe and overflow are high for exactly one cycle per press, however long the key is held.
- A glitch shorter than DEBOUNCE cycles produces no strobe and returns the FSM to IDLE.
- Minimum spacing between two accepts is DEBOUNCE+1 cycles: one release cycle plus the debounce interval.
- en falling during DEBOUNCE aborts the press. en falling in WAIT_REL has no effect.
- Asynchronous reset mid-press forces IDLE and zeroes all outputs immediately. After reset is released, a key still held is treated as a new press.
- A multi-hot press after acceptance, while in WAIT_REL, is ignored; error is not set.

## Test plan
- Reset, then en=1 and dec=0000001000 held for 3 cycles -> strobe pulses once at the 3rd edge; digits=0x0003, count=1, last_bcd=3; busy until release.
- Keys 1,2,0,5,9 pressed and released with OVERWRITE=1 -> digits=0x2059, count=4, full=1. With OVERWRITE=0 -> digits=0x1205, overflow pulses on key 9.
- dec=0000000100 for 2 cycles then 0 (DEBOUNCE=3) -> no strobe, digits unchanged, FSM returns to IDLE.
- dec=1000000100 with en=1 -> error=1, no strobe. error stays set until clear=1, which zeroes digits, count and error.
- en=0 with every one-hot key applied in turn -> no strobe, digits stay 0. Then en=1 with key 7 held -> exactly one accept (0x0007).
- rst_n pulsed low mid-DEBOUNCE with key 4 held -> outputs 0 asynchronously. After release, key 4 is accepted DEBOUNCE cycles later.
